sort_job_ctrl: RTL and testbench

Job-level controller wrapped around the selection-sort engine and its single-port RAM. It accepts an unsorted element stream and writes it into RAM, then hands the RAM to the sort engine and fires its start. After completion it takes the RAM back and streams the sorted contents out with valid/ready. It owns the RAM port mux select, so the host never touches the engine's RAM or start/done directly.

---
 rtl/sort_job_pkg.sv | 24 ++
 rtl/sort_job_wdog.sv | 30 +++
 rtl/sort_job_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sort_job_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_job_pkg.sv
// Shared types and constants for the sort job controller.
// Holds the FSM state encoding and the job-capacity helper.
package sort_job_pkg;

    localparam int SORT_SIZE_ADDR = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SORT_START,
        S_SORT_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_OUT
    } state_t;

    typedef logic [SORT_SIZE_ADDR-1:0] count_t;

    // One RAM slot is kept spare so the element count fits in SIZE_ADDR bits.
    function automatic int n_max(input int size_addr);
        return (1 << size_addr) - 1;
    endfunction

endpackage

// File: rtl/sort_job_wdog.sv
// Watchdog: loadable down-counter with clear/enable; expired while the count is zero.
// Latency: load/decrement take effect on the next clock; expired is combinational on the count.
// Backpressure: none; the counter saturates at zero.
module sort_job_wdog #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sort_job_ctrl.sv
// Job controller: loads a stream into RAM, runs the sort engine, streams sorted data out.
// Latency: start 1 cycle after last input; first output 3 cycles after done; 3 cycles/element readback.
// Backpressure: o_in_ready only in IDLE/LOAD; output held stable while o_out_valid && !i_out_ready.
module sort_job_ctrl
    import sort_job_pkg::*;
#(
    parameter int SIZE_ADDR   = 4,
    parameter int SIZE_DATA   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [SIZE_DATA-1:0] i_in_data,
    input  logic                 i_in_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [SIZE_DATA-1:0] o_out_data,
    output logic                 o_out_last,
    output logic                 o_sort_start,
    output logic [SIZE_ADDR-1:0] o_sort_num_elems,
    input  logic                 i_sort_done,
    output logic                 o_ram_sel,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    output logic [SIZE_DATA-1:0] o_ram_din,
    output logic                 o_ram_wr_en,
    input  logic [SIZE_DATA-1:0] i_ram_dout,
    output logic                 o_busy,
    output logic                 o_err_overflow,
    output logic                 o_err_timeout
);

    localparam logic [SIZE_ADDR-1:0] N_MAX = SIZE_ADDR'(n_max(SIZE_ADDR));
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_t               state, state_nxt;
    logic [SIZE_ADDR-1:0] count, count_nxt;
    logic [SIZE_ADDR-1:0] rd_idx, rd_idx_nxt;
    logic [SIZE_DATA-1:0] out_dat, out_dat_nxt;
    logic                 err_ovf, err_ovf_nxt;
    logic                 err_to, err_to_nxt;
    logic                 start_raw;
    logic                 wd_load, wd_en, wd_expired;
    logic                 has_room;
    logic [SIZE_ADDR-1:0] load_cnt;

    assign has_room = (count != N_MAX);
    assign load_cnt = has_room ? count + SIZE_ADDR'(1) : count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            count   <= '0;
            rd_idx  <= '0;
            out_dat <= '0;
            err_ovf <= 1'b0;
            err_to  <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            rd_idx  <= rd_idx_nxt;
            out_dat <= out_dat_nxt;
            err_ovf <= err_ovf_nxt;
            err_to  <= err_to_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        rd_idx_nxt  = rd_idx;
        out_dat_nxt = out_dat;
        err_ovf_nxt = err_ovf;
        err_to_nxt  = err_to;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_out_last  = 1'b0;
        start_raw   = 1'b0;
        o_ram_sel   = 1'b1;
        o_ram_addr  = '0;
        o_ram_din   = '0;
        o_ram_wr_en = 1'b0;
        wd_load     = 1'b0;
        wd_en       = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                o_in_ready = 1'b1;
                rd_idx_nxt = '0;
                if (i_in_valid) begin
                    if (has_room) begin
                        o_ram_wr_en = 1'b1;
                        o_ram_addr  = count;
                        o_ram_din   = i_in_data;
                        count_nxt   = count + SIZE_ADDR'(1);
                    end else begin
                        err_ovf_nxt = 1'b1;
                    end
                    state_nxt = S_LOAD;
                    // A single-element job is already sorted.
                    if (i_in_last) begin
                        state_nxt = (load_cnt[SIZE_ADDR-1:1] != '0) ? S_SORT_START : S_RD_ADDR;
                    end
                end
            end
            S_SORT_START: begin
                o_ram_sel = 1'b0;
                start_raw = 1'b1;
                wd_load   = 1'b1;
                state_nxt = S_SORT_WAIT;
            end
            S_SORT_WAIT: begin
                o_ram_sel = 1'b0;
                wd_en     = 1'b1;
                // Done wins over a same-cycle timeout.
                if (i_sort_done) begin
                    rd_idx_nxt = '0;
                    state_nxt  = S_RD_ADDR;
                end else if (wd_expired) begin
                    err_to_nxt = 1'b1;
                    count_nxt  = '0;
                    state_nxt  = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                o_ram_addr = rd_idx;
                state_nxt  = S_RD_DATA;
            end
            S_RD_DATA: begin
                o_ram_addr  = rd_idx;
                out_dat_nxt = i_ram_dout;
                state_nxt   = S_OUT;
            end
            S_OUT: begin
                o_out_valid = 1'b1;
                o_out_last  = (rd_idx == count - SIZE_ADDR'(1));
                if (i_out_ready) begin
                    if (o_out_last) begin
                        count_nxt = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        rd_idx_nxt = rd_idx + SIZE_ADDR'(1);
                        state_nxt  = S_RD_ADDR;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    sort_job_wdog #(.WIDTH(WD_W)) u_wdog (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (state == S_IDLE),
        .load     (wd_load),
        .load_val (WD_W'(TIMEOUT_CYC - 1)),
        .en       (wd_en),
        .expired  (wd_expired)
    );

    assign o_sort_start     = start_raw & ~i_rst;
    assign o_sort_num_elems = count;
    assign o_out_data       = out_dat;
    assign o_busy           = (state != S_IDLE);
    assign o_err_overflow   = err_ovf;
    assign o_err_timeout    = err_to;

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Directed bench for sort_job_ctrl with a behavioural RAM and sort-engine model.
module tb_sort_job_ctrl;

    typedef logic [7:0] mem_t [16];

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_in_valid = 1'b0;
    logic [7:0] i_in_data = 8'h00;
    logic       i_in_last = 1'b0;
    logic       i_out_ready = 1'b0;
    logic       o_in_ready, o_out_valid, o_out_last, o_sort_start;
    logic [7:0] o_out_data, o_ram_din;
    logic [3:0] o_sort_num_elems, o_ram_addr;
    logic       o_ram_sel, o_ram_wr_en, o_busy, o_err_overflow, o_err_timeout;
    logic       i_sort_done;
    logic [7:0] ram_dout = 8'h00;

    logic       sort_done = 1'b0;
    logic       spur_done = 1'b0;
    logic       eng_en = 1'b1;
    int         eng_cnt = 0;
    int         eng_n = 0;
    int         start_cnt = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    mem_t       mem;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got_q[$];
    logic       last_q[$];

    assign i_sort_done = sort_done | spur_done;

    always #5 i_clk = ~i_clk;

    sort_job_ctrl #(.SIZE_ADDR(4), .SIZE_DATA(8), .TIMEOUT_CYC(4096)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_in_valid       (i_in_valid),
        .o_in_ready       (o_in_ready),
        .i_in_data        (i_in_data),
        .i_in_last        (i_in_last),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_out_data       (o_out_data),
        .o_out_last       (o_out_last),
        .o_sort_start     (o_sort_start),
        .o_sort_num_elems (o_sort_num_elems),
        .i_sort_done      (i_sort_done),
        .o_ram_sel        (o_ram_sel),
        .o_ram_addr       (o_ram_addr),
        .o_ram_din        (o_ram_din),
        .o_ram_wr_en      (o_ram_wr_en),
        .i_ram_dout       (ram_dout),
        .o_busy           (o_busy),
        .o_err_overflow   (o_err_overflow),
        .o_err_timeout    (o_err_timeout)
    );

    function automatic mem_t sort_mem(input mem_t m, input int n);
        mem_t       r;
        logic [7:0] t;
        r = m;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < n - 1 - a; b++)
                if (r[b] > r[b+1]) begin
                    t = r[b]; r[b] = r[b+1]; r[b+1] = t;
                end
        return r;
    endfunction

    // RAM with 1-cycle read latency plus an engine that sorts in place after a fixed delay.
    always @(posedge i_clk) begin
        if (o_ram_sel && o_ram_wr_en) mem[o_ram_addr] <= o_ram_din;
        ram_dout  <= mem[o_ram_addr];
        sort_done <= 1'b0;
        if (sort_done) done_cyc <= cyc;
        cyc <= cyc + 1;
        if (i_rst) begin
            eng_cnt <= 0;
        end else if (o_sort_start) begin
            eng_cnt   <= 20;
            eng_n     <= int'(o_sort_num_elems);
            start_cnt <= start_cnt + 1;
        end else if (eng_cnt == 1) begin
            eng_cnt <= 0;
            if (eng_en) begin
                mem       <= sort_mem(mem, eng_n);
                sort_done <= 1'b1;
            end
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] d[$], input int n_wr, input bit spur);
        for (int i = 0; i < d.size(); i++) begin
            @(negedge i_clk);
            i_in_valid = 1'b1;
            i_in_data  = d[i];
            i_in_last  = (i == d.size() - 1);
            spur_done  = spur && (i == 1);
            #1;
            chk("in_ready", o_in_ready, 1);
            chk("wr_en", o_ram_wr_en, i < 15);
            if (i < 15) begin
                chk("wr_addr", o_ram_addr, i);
                chk("wr_din", o_ram_din, d[i]);
            end
        end
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        spur_done  = 1'b0;
        chk("sort_start", o_sort_start, n_wr >= 2);
        chk("ram_sel_start", o_ram_sel, n_wr < 2);
        if (n_wr >= 2) chk("num_elems", o_sort_num_elems, n_wr);
    endtask

    task automatic collect(input int n, input bit rnd, output int first_cyc);
        bit         pv;
        bit         r;
        logic [7:0] pd;
        logic       pl;
        int         budget;
        pv = 1'b0; pd = 8'h00; pl = 1'b0; budget = 0; first_cyc = -1;
        got_q.delete();
        last_q.delete();
        while (budget < 2000 && got_q.size() < n) begin
            budget++;
            @(negedge i_clk);
            if (pv) begin
                chk("stall_valid", o_out_valid, 1);
                chk("stall_data", o_out_data, pd);
                chk("stall_last", o_out_last, pl);
            end
            r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_out_ready = r;
            if (o_out_valid && first_cyc < 0) first_cyc = cyc;
            pv = o_out_valid && !r;
            pd = o_out_data;
            pl = o_out_last;
            if (o_out_valid && r) begin
                got_q.push_back(o_out_data);
                last_q.push_back(o_out_last);
            end
        end
        chk("out_count", got_q.size(), n);
        @(negedge i_clk);
        i_out_ready = 1'b0;
        chk("idle_after_out", o_busy, 0);
    endtask

    task automatic check_out(input logic [7:0] e[$]);
        for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
            chk("out_data", got_q[i], e[i]);
            chk("out_last", last_q[i], i == e.size() - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] e[$];
        int         fc;
        int         s0;

        repeat (2) @(negedge i_clk);
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_ram_sel", o_ram_sel, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_sort_start", o_sort_start, 0);
        chk("rst_num_elems", o_sort_num_elems, 0);
        chk("rst_err_ovf", o_err_overflow, 0);
        chk("rst_err_to", o_err_timeout, 0);
        chk("rst_wr_en", o_ram_wr_en, 0);
        i_rst = 1'b0;

        // Ten-element job.
        d = '{8'h5A, 8'h03, 8'hFF, 8'h10, 8'h10, 8'h00, 8'h7E, 8'h81, 8'h22, 8'h01};
        e = '{8'h00, 8'h01, 8'h03, 8'h10, 8'h10, 8'h22, 8'h5A, 8'h7E, 8'h81, 8'hFF};
        s0 = start_cnt;
        load(d, 10, 1'b0);
        collect(10, 1'b0, fc);
        chk("first_out_latency", fc - done_cyc, 3);
        check_out(e);
        chk("ten_start_count", start_cnt - s0, 1);
        chk("ten_eng_n", eng_n, 10);

        // Single element skips the sort.
        d = '{8'h42};
        e = '{8'h42};
        s0 = start_cnt;
        load(d, 1, 1'b0);
        collect(1, 1'b0, fc);
        check_out(e);
        chk("single_no_start", start_cnt - s0, 0);
        chk("single_no_ovf", o_err_overflow, 0);

        // Overflow: 17 beats, first 15 kept.
        d.delete();
        e.delete();
        for (int i = 0; i < 17; i++) d.push_back(8'((16 - i) * 5));
        for (int k = 0; k < 15; k++) e.push_back(8'(10 + 5 * k));
        load(d, 15, 1'b0);
        chk("ovf_flag", o_err_overflow, 1);
        collect(15, 1'b0, fc);
        check_out(e);
        chk("ovf_eng_n", eng_n, 15);

        // Random output stalls with a spurious done during load.
        d = '{8'h30, 8'h10, 8'h20, 8'h50, 8'h40};
        e = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        s0 = start_cnt;
        load(d, 5, 1'b1);
        collect(5, 1'b1, fc);
        check_out(e);
        chk("stall_start_count", start_cnt - s0, 1);
        chk("ovf_sticky", o_err_overflow, 1);

        // Timeout: engine never completes.
        eng_en = 1'b0;
        d = '{8'h03, 8'h02, 8'h01};
        load(d, 3, 1'b0);
        repeat (4096) @(negedge i_clk);
        chk("to_before", o_err_timeout, 0);
        chk("to_busy_before", o_busy, 1);
        @(negedge i_clk);
        chk("to_flag", o_err_timeout, 1);
        chk("to_idle", o_busy, 0);
        chk("to_in_ready", o_in_ready, 1);

        // Reset during SORT_WAIT, then a fresh job.
        d = '{8'h09, 8'h07, 8'h08};
        e = '{8'h07, 8'h08, 8'h09};
        load(d, 3, 1'b0);
        repeat (10) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ram_sel", o_ram_sel, 1);
        chk("mid_rst_in_ready", o_in_ready, 1);
        chk("mid_rst_sort_start", o_sort_start, 0);
        chk("mid_rst_out_valid", o_out_valid, 0);
        chk("mid_rst_num_elems", o_sort_num_elems, 0);
        chk("mid_rst_err_to", o_err_timeout, 0);
        chk("mid_rst_err_ovf", o_err_overflow, 0);
        i_rst = 1'b0;
        eng_en = 1'b1;
        load(d, 3, 1'b0);
        collect(3, 1'b0, fc);
        check_out(e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
